// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-side and controller-side signals of the traffic sensor conditioner.
// The conditioner takes the slave view; the stimulus side takes the master view.
interface traffic_sensor_conditioner_if;
  logic       sens_main;
  logic       sens_side;
  logic       force_off;
  logic [1:0] in_code;
  logic       en_tick;
  logic       req_valid;

  modport master (
    output sens_main, sens_side, force_off,
    input  in_code, en_tick, req_valid
  );

  modport slave (
    input  sens_main, sens_side, force_off,
    output in_code, en_tick, req_valid
  );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for the traffic-light controller: sync, debounce and hold-stretch
// two vehicle sensors into a 2-bit request code, and generate the periodic enable tick.
module traffic_sensor_conditioner #(
  parameter int unsigned DEB_CYC  = 4,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned TICK_DIV = 2
) (
  input  logic                          clk,
  input  logic                          res,
  traffic_sensor_conditioner_if.slave   bus
);

  localparam int unsigned DebW  = $clog2(DEB_CYC + 1);
  localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYC - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYC - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StActive, StHold} ch_state_e;

  // Channel 0 is the main road, channel 1 the side road.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [DebW-1:0]  deb_cnt_q [2];
  logic [DebW-1:0]  deb_cnt_d [2];
  ch_state_e        state_q [2];
  ch_state_e        state_d [2];
  logic [HoldW-1:0] hold_q [2];
  logic [HoldW-1:0] hold_d [2];
  logic [1:0]       req;
  logic [1:0]       in_code_q, in_code_d;
  logic             req_valid_q, req_valid_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             en_tick_q, en_tick_d;

  assign raw = {bus.sens_side, bus.sens_main};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    req     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      state_d[i]   = state_q[i];
      hold_d[i]    = hold_q[i];
      req[i]       = (state_q[i] != StIdle);

      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end

      if (bus.force_off) begin
        state_d[i] = StIdle;
        hold_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (deb_q[i]) state_d[i] = StActive;
          end
          StActive: begin
            if (!deb_q[i]) begin
              state_d[i] = StHold;
              hold_d[i]  = HoldLoad;
            end
          end
          StHold: begin
            // A re-assertion during hold keeps the request up without a gap.
            if (deb_q[i]) begin
              state_d[i] = StActive;
              hold_d[i]  = '0;
            end else if (hold_q[i] == '0) begin
              state_d[i] = StIdle;
            end else begin
              hold_d[i] = hold_q[i] - 1'b1;
            end
          end
          default: state_d[i] = StIdle;
        endcase
      end
    end

    in_code_d   = bus.force_off ? 2'b00 : req;
    req_valid_d = (in_code_d != 2'b00);

    en_tick_d  = (tick_cnt_q == TickLast);
    tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      in_code_q   <= '0;
      req_valid_q <= 1'b0;
      tick_cnt_q  <= '0;
      en_tick_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
        state_q[i]   <= StIdle;
        hold_q[i]    <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      in_code_q   <= in_code_d;
      req_valid_q <= req_valid_d;
      tick_cnt_q  <= tick_cnt_d;
      en_tick_q   <= en_tick_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        state_q[i]   <= state_d[i];
        hold_q[i]    <= hold_d[i];
      end
    end
  end

  assign bus.in_code   = in_code_q;
  assign bus.req_valid = req_valid_q;
  assign bus.en_tick   = en_tick_q;

endmodule
